// File: rtl/riscv_tb_pkg.sv
// Shared types and helpers for the RISC-V end-of-test monitor.
// Holds the state/fail-code enums, the MODE bit positions and a saturating increment.
package riscv_tb_pkg;

    localparam int unsigned CNT_W = 32;

    localparam int unsigned MODE_BIT_INSTR = 0;
    localparam int unsigned MODE_BIT_PC    = 1;
    localparam int unsigned MODE_BIT_LOOP  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_PASS = 2'b10,
        ST_FAIL = 2'b11
    } mon_state_e;

    typedef enum logic [1:0] {
        FAIL_NONE    = 2'b00,
        FAIL_TIMEOUT = 2'b01,
        FAIL_STALL   = 2'b10,
        FAIL_ILLEGAL = 2'b11
    } fail_code_e;

    // Counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/trace_ring_buffer.sv
// Ring buffer of the most recent retired {pc, instr} pairs.
// Reads are addressed relative to the newest entry (rd_idx 0 = newest).
module trace_ring_buffer #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             push,
    input  logic [XLEN-1:0]                  pc,
    input  logic [XLEN-1:0]                  instr,
    input  logic [$clog2(TRACE_DEPTH)-1:0]   rd_idx,
    output logic [XLEN-1:0]                  rd_pc_c,
    output logic [XLEN-1:0]                  rd_instr_c,
    output logic [$clog2(TRACE_DEPTH):0]     count
);

    localparam int unsigned IDX_W = $clog2(TRACE_DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [XLEN-1:0]  pc_mem    [TRACE_DEPTH];
    logic [XLEN-1:0]  instr_mem [TRACE_DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_addr_c;

    // Clear only rewinds pointer/count; stale contents stay until overwritten
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(TRACE_DEPTH); i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            pc_mem[wr_ptr]    <= pc;
            instr_mem[wr_ptr] <= instr;
            wr_ptr            <= wr_ptr + IDX_W'(1);
            if (count != CNT_W'(TRACE_DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Power-of-two depth lets the subtraction wrap naturally
    assign rd_addr_c  = wr_ptr - IDX_W'(1) - rd_idx;
    assign rd_pc_c    = pc_mem[rd_addr_c];
    assign rd_instr_c = instr_mem[rd_addr_c];

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor: watches the retire stream, detects the end condition and
// classifies pass/timeout/stall/illegal, keeping counts and a post-mortem trace.
module riscv_test_monitor
    import riscv_tb_pkg::*;
#(
    parameter int unsigned     XLEN           = 32,
    parameter int unsigned     TIMEOUT_CYCLES = 100,
    parameter int unsigned     STALL_CYCLES   = 16,
    parameter int unsigned     TRACE_DEPTH    = 8,
    parameter logic [XLEN-1:0] END_INSTR      = XLEN'(32'h0000_0013),
    parameter logic [XLEN-1:0] END_PC         = XLEN'(32'h0000_0000),
    parameter logic [2:0]      MODE           = 3'b001
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             valid,
    input  logic [XLEN-1:0]                  pc,
    input  logic [XLEN-1:0]                  instr,
    output logic                             done,
    output logic                             pass,
    output logic [1:0]                       fail_code,
    output logic [31:0]                      cycle_count,
    output logic [31:0]                      retired_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0]   trace_idx,
    output logic [XLEN-1:0]                  trace_pc,
    output logic [XLEN-1:0]                  trace_instr,
    output logic [$clog2(TRACE_DEPTH):0]     trace_count
);

    mon_state_e       state_q, state_d;
    fail_code_e       fail_q, fail_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [XLEN-1:0]  prev_pc_q, prev_pc_d;
    logic             prev_valid_q, prev_valid_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             end_match_c;
    logic             trace_clear_c;
    logic             trace_push_c;

    assign end_match_c = (MODE[MODE_BIT_INSTR] && (instr == END_INSTR))
                      || (MODE[MODE_BIT_PC]    && (pc == END_PC))
                      || (MODE[MODE_BIT_LOOP]  && prev_valid_q && (pc == prev_pc_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fail_q       <= FAIL_NONE;
            cycle_q      <= '0;
            retired_q    <= '0;
            stall_q      <= '0;
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fail_q       <= fail_d;
            cycle_q      <= cycle_d;
            retired_q    <= retired_d;
            stall_q      <= stall_d;
            prev_pc_q    <= prev_pc_d;
            prev_valid_q <= prev_valid_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    // Next state; result priority on a single cycle is pass > illegal > stall > timeout
    always_comb begin
        state_d       = state_q;
        fail_d        = fail_q;
        cycle_d       = cycle_q;
        retired_d     = retired_q;
        stall_d       = stall_q;
        prev_pc_d     = prev_pc_q;
        prev_valid_d  = prev_valid_q;
        done_d        = done_q;
        pass_d        = pass_q;
        trace_clear_c = 1'b0;
        trace_push_c  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) begin
                    state_d       = ST_RUN;
                    fail_d        = FAIL_NONE;
                    cycle_d       = '0;
                    retired_d     = '0;
                    stall_d       = '0;
                    prev_valid_d  = 1'b0;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    trace_clear_c = 1'b1;
                end
            end
            ST_RUN: begin
                cycle_d = sat_inc(cycle_q);
                if (valid) begin
                    retired_d    = sat_inc(retired_q);
                    stall_d      = '0;
                    prev_pc_d    = pc;
                    prev_valid_d = 1'b1;
                    trace_push_c = 1'b1;
                end else begin
                    stall_d = sat_inc(stall_q);
                end

                if (valid && end_match_c) begin
                    state_d = ST_PASS;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else if (valid && (instr == '0)) begin
                    state_d = ST_FAIL;
                    done_d  = 1'b1;
                    fail_d  = FAIL_ILLEGAL;
                end else if (!valid && (stall_q == CNT_W'(STALL_CYCLES - 1))) begin
                    state_d = ST_FAIL;
                    done_d  = 1'b1;
                    fail_d  = FAIL_STALL;
                end else if (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_FAIL;
                    done_d  = 1'b1;
                    fail_d  = FAIL_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign done          = done_q;
    assign pass          = pass_q;
    assign fail_code     = fail_q;
    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;

    trace_ring_buffer #(
        .XLEN        (XLEN),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk        (clk),
        .rst        (rst),
        .clear      (trace_clear_c),
        .push       (trace_push_c),
        .pc         (pc),
        .instr      (instr),
        .rd_idx     (trace_idx),
        .rd_pc_c    (trace_pc),
        .rd_instr_c (trace_instr),
        .count      (trace_count)
    );

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Self-checking bench for riscv_test_monitor: two instances (MODE 001 and 100) share
// one stimulus stream and are compared against a cycle-list reference model.
module tb_riscv_test_monitor;

    localparam int unsigned TO = 100;
    localparam int unsigned ST = 16;
    localparam int unsigned TD = 8;
    localparam int unsigned IW = 3;
    localparam logic [2:0]  M0 = 3'b001;
    localparam logic [2:0]  M1 = 3'b100;
    localparam logic [31:0] END_I = 32'h0000_0013;
    localparam logic [31:0] END_P = 32'h0000_0000;
    localparam logic [31:0] ADDI  = 32'h0010_0093;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [31:0]   pc = '0;
    logic [31:0]   instr = '0;
    logic [IW-1:0] trace_idx = '0;

    logic          done0, pass0, done1, pass1;
    logic [1:0]    fc0, fc1;
    logic [31:0]   cc0, rc0, tp0, ti0, cc1, rc1, tp1, ti1;
    logic [IW:0]   tc0, tc1;

    int total = 0;
    int bad   = 0;

    // Stimulus: one entry per RUN cycle after start
    int          n;
    logic        sv [200];
    logic [31:0] sp [200];
    logic [31:0] si [200];

    // Expected results per instance
    int          e_end [2];
    int          e_cyc [2];
    int          e_ret [2];
    int          e_tc  [2];
    logic        e_done [2];
    logic        e_pass [2];
    logic [1:0]  e_code [2];
    logic [63:0] e_tr [2][TD];

    always #5 clk = ~clk;

    riscv_test_monitor #(.MODE(M0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .pc(pc), .instr(instr),
        .done(done0), .pass(pass0), .fail_code(fc0), .cycle_count(cc0),
        .retired_count(rc0), .trace_idx(trace_idx), .trace_pc(tp0),
        .trace_instr(ti0), .trace_count(tc0)
    );

    riscv_test_monitor #(.MODE(M1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .pc(pc), .instr(instr),
        .done(done1), .pass(pass1), .fail_code(fc1), .cycle_count(cc1),
        .retired_count(rc1), .trace_idx(trace_idx), .trace_pc(tp1),
        .trace_instr(ti1), .trace_count(tc1)
    );

    task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    // Walk the cycle list applying the end rules directly
    task automatic model(input int d, input logic [2:0] mode);
        int          stall;
        int          ret;
        bit          prevv;
        bit          ended;
        bit          match;
        logic [31:0] prevpc;
        int          beats [$];
        stall = 0; ret = 0; prevv = 0; ended = 0; prevpc = '0;
        e_end[d] = -1; e_pass[d] = 1'b0; e_code[d] = 2'b00; e_cyc[d] = 0;
        for (int k = 0; k < n; k++) begin
            e_cyc[d] = k + 1;
            match = 0;
            if (sv[k]) begin
                match = (mode[0] && si[k] == END_I) || (mode[1] && sp[k] == END_P)
                     || (mode[2] && prevv && sp[k] == prevpc);
                ret++;
                beats.push_back(k);
                prevv = 1; prevpc = sp[k]; stall = 0;
            end else begin
                stall++;
            end
            if (sv[k] && match) begin ended = 1; e_pass[d] = 1'b1; end
            else if (sv[k] && si[k] == 32'h0) begin ended = 1; e_code[d] = 2'b11; end
            else if (!sv[k] && stall == int'(ST)) begin ended = 1; e_code[d] = 2'b10; end
            else if (k + 1 == int'(TO)) begin ended = 1; e_code[d] = 2'b01; end
            if (ended) begin e_end[d] = k; break; end
        end
        e_done[d] = ended;
        e_ret[d]  = ret;
        e_tc[d]   = (ret < int'(TD)) ? ret : int'(TD);
        for (int j = 0; j < e_tc[d]; j++) begin
            e_tr[d][j] = {sp[beats[ret-1-j]], si[beats[ret-1-j]]};
        end
    endtask

    task automatic check_zero(input int d);
        logic [67:0] v;
        v = d ? {done1, pass1, fc1, cc1, rc1} : {done0, pass0, fc0, cc0, rc0};
        chk("reset_outputs", d, v[63:0], 64'h0);
        chk("reset_trace_count", d, 64'(d ? tc1 : tc0), 64'h0);
        trace_idx = '0;
        #1;
        chk("reset_trace_data", d, d ? {tp1, ti1} : {tp0, ti0}, 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero(0);
        check_zero(1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_result(input int d, input int first_k);
        chk("done", d, 64'(d ? done1 : done0), 64'(e_done[d]));
        chk("pass", d, 64'(d ? pass1 : pass0), 64'(e_pass[d]));
        chk("fail_code", d, 64'(d ? fc1 : fc0), 64'(e_code[d]));
        chk("cycle_count", d, 64'(d ? cc1 : cc0), 64'(e_cyc[d]));
        chk("retired_count", d, 64'(d ? rc1 : rc0), 64'(e_ret[d]));
        chk("trace_count", d, 64'(d ? tc1 : tc0), 64'(e_tc[d]));
        chk("done_beat", d, 64'(first_k), 64'(e_end[d]));
    endtask

    task automatic check_trace(input int d);
        for (int j = 0; j < e_tc[d]; j++) begin
            trace_idx = IW'(j);
            #1;
            chk("trace_entry", d, d ? {tp1, ti1} : {tp0, ti0}, e_tr[d][j]);
        end
    endtask

    task automatic run_scn();
        int first [2];
        if (!(done0 && done1)) do_reset();
        model(0, M0);
        model(1, M1);
        first[0] = -1;
        first[1] = -1;
        @(negedge clk);
        start = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            valid = sv[k]; pc = sp[k]; instr = si[k];
            @(posedge clk);
            #1;
            if (done0 && first[0] < 0) first[0] = k;
            if (done1 && first[1] < 0) first[1] = k;
            if (k < n - 1) @(negedge clk);
        end
        check_result(0, first[0]);
        check_result(1, first[1]);
        valid = 1'b0; pc = '0; instr = '0;
        check_trace(0);
        check_trace(1);
    endtask

    initial begin
        #3;
        check_zero(0);
        check_zero(1);
        @(negedge clk);
        rst = 1'b0;

        // Five ADDIs then the end NOP
        n = 6;
        for (int k = 0; k < n; k++) begin
            sv[k] = 1'b1; sp[k] = 32'(4 * k); si[k] = (k == 5) ? END_I : ADDI;
        end
        run_scn();

        // Continuous non-ending retire -> timeout
        n = 110;
        for (int k = 0; k < n; k++) begin
            sv[k] = 1'b1; sp[k] = 32'(4 * k + 4); si[k] = ADDI;
        end
        run_scn();

        // Three beats then silence -> stall
        n = 25;
        for (int k = 0; k < n; k++) begin
            sv[k] = (k < 3); sp[k] = 32'(4 * k + 4); si[k] = ADDI;
        end
        run_scn();

        // Self-loop PCs 0,4,8,8
        n = 4;
        for (int k = 0; k < n; k++) begin
            sv[k] = 1'b1; sp[k] = (k == 3) ? 32'h8 : 32'(4 * k); si[k] = ADDI;
        end
        run_scn();
        si[3] = 32'h0;
        run_scn();

        // Twelve beats, trace wraps
        n = 12;
        for (int k = 0; k < n; k++) begin
            sv[k] = 1'b1; sp[k] = 32'(32'h100 + 4 * k); si[k] = ADDI + 32'(k << 7);
        end
        run_scn();

        // Reset in the middle of a run
        if (!(done0 && done1)) do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            valid = 1'b1; pc = 32'(32'h200 + 4 * k); instr = ADDI;
            @(negedge clk);
        end
        valid = 1'b0;
        #2;
        chk("pre_reset_retired", 0, 64'(rc0), 64'd5);
        chk("pre_reset_retired", 1, 64'(rc1), 64'd5);
        rst = 1'b1;
        #1;
        check_zero(0);
        check_zero(1);
        @(negedge clk);
        rst = 1'b0;

        // Randomised runs
        for (int r = 0; r < 6; r++) begin
            n = (r == 5) ? 120 : 40;
            for (int k = 0; k < n; k++) begin
                sv[k] = (r % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
                sp[k] = 32'(4 * $urandom_range(0, 5));
                case ($urandom_range(0, 19))
                    0:       si[k] = END_I;
                    1:       si[k] = 32'h0;
                    default: si[k] = $urandom | 32'h1;
                endcase
                if (si[k] == END_I && r == 5) si[k] = ADDI;
            end
            run_scn();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesizable end-of-test monitor for the RISC-V core: watches the core's debug PC/instruction retire stream, detects a configurable end condition, and reports pass or a classified failure with cycle and retire counts. Keeps a ring-buffer trace of the last TRACE_DEPTH retired PC/instruction pairs for post-mortem readout. Sits beside `riscv_core_top` in simulation and FPGA bring-up builds, replacing fixed-timeout, NOP-only checking done ad hoc in the bench.

## Interface
- XLEN, 32, PC and instruction width
- TIMEOUT_CYCLES, 100, cycles in RUN before timeout fail; must be ≥1
- STALL_CYCLES, 16, consecutive cycles with no `valid` before stall fail; must be ≥1
- TRACE_DEPTH, 8, trace entries; power of two, ≥2
- END_INSTR, 32'h00000013, instruction that ends the test (MODE[0])
- END_PC, 32'h0, PC that ends the test (MODE[1])
- MODE, 3'b001, bit0 instruction match, bit1 PC match, bit2 self-loop match (retired PC equals the previous retired PC)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; arms the monitor
- valid  in  1  one instruction retired this cycle
- pc  in  XLEN  PC of retiring instruction
- instr  in  XLEN  retiring instruction word
- done  out  1  test finished (PASS or FAIL), level
- pass  out  1  finished with pass, level
- fail_code  out  2  00 none, 01 timeout, 10 stall, 11 illegal (instr == 0)
- cycle_count  out  32  cycles spent in RUN, saturating
- retired_count  out  32  valid beats in RUN, saturating
- trace_idx  in  $clog2(TRACE_DEPTH)  read index, 0 = newest
- trace_pc  out  XLEN  PC at trace_idx
- trace_instr  out  XLEN  instruction at trace_idx
- trace_count  out  $clog2(TRACE_DEPTH)+1  valid entries, saturates at TRACE_DEPTH

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset → IDLE; all outputs 0; trace contents 0.
- IDLE: `start` → RUN; clears counters, stall counter, trace_count, trace pointer, prev-PC-valid flag. `valid` ignored.
- RUN: cycle_count +1 each cycle. On `valid`: retired_count +1, push {pc, instr} to trace, stall counter clears; otherwise stall counter +1.
- End match (on valid beat): (MODE[0] & instr==END_INSTR) | (MODE[1] & pc==END_PC) | (MODE[2] & prev-PC-valid & pc==prev PC). MODE==0 never matches; the test ends only by failure.
- Same-cycle priority: pass > illegal > stall > timeout. Timeout: cycle_count reaches TIMEOUT_CYCLES-1 in this cycle. Stall: stall counter reaches STALL_CYCLES-1 with no valid.
- The terminating beat is included in the trace and in retired_count.
- PASS/FAIL: hold all outputs and freeze the trace. `start` restarts exactly as from IDLE. `start` in RUN is ignored.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- Trace: write pointer wraps modulo TRACE_DEPTH. Read address = (wr_ptr − 1 − trace_idx) mod TRACE_DEPTH. An index ≥ trace_count returns stale or zero data; this case is not checked.

## Timing
- State, done, pass, fail_code, and counters are registered. They update on the clk edge that samples the deciding beat. done is visible one cycle after the terminating valid is presented.
- trace_pc/trace_instr are combinational from trace_idx and the registered array. A pushed entry is readable the cycle after its valid.
- `rst` asserted at any time, including mid-RUN: immediate return to IDLE, outputs 0. Deassertion is synchronised by the surrounding design.

## Structure
- `riscv_tb_pkg`: state enum, fail_code enum (FAIL_NONE/TIMEOUT/STALL/ILLEGAL), MODE bit index constants.
- One sub-module, `trace_ring_buffer`, parametrised by XLEN and TRACE_DEPTH. It owns push, wrap, count, clear, and newest-relative read.

## Test plan
- Default params; start, then retire 5 ADDIs with 0x00000013 on the 6th beat → done=1, pass=1, fail_code=00, retired_count=6, trace_idx=0 gives instr 0x00000013.
- Start, then valid every cycle with a nonzero non-ending instruction → done at cycle_count=100, fail_code=01.
- Start, 3 valid beats, then valid held low → fail_code=10 after 16 idle cycles, retired_count=3.
- MODE=3'b100; PCs 0x0, 0x4, 0x8, 0x8 → pass on the 4th beat. Same test with instr=0 on the 4th beat → pass (priority).
- 12 beats with TRACE_DEPTH=8 and no end → trace_count=8, trace_idx=7 returns beat 5 (counting from 1).
- Assert rst mid-RUN → next cycle done=0, counters 0, state IDLE; a fresh start runs normally.
